// File: rtl/pdm_cic_decimator.sv
// Fourth-order CIC decimator for signed 2-bit PDM samples (ratio 2^LOG2_DEC).
// Produces saturated OUT_W-bit PCM once the comb pipeline has settled.
module pdm_cic_decimator #(
  parameter int LOG2_DEC = 6,
  parameter int OUT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [1:0]              pdm_i,
  input  logic                    pdm_val_i,
  output logic signed [OUT_W-1:0] pcm_o,
  output logic                    pcm_val_o,
  output logic                    settled_o
);

  localparam int ACC_W = 2 + 4 * LOG2_DEC;
  localparam int SHIFT = ACC_W - 1 - OUT_W;
  localparam int N_STG = 4;
  localparam logic [2:0] SETTLE_N = 3'd4;
  localparam logic [LOG2_DEC-1:0] CNT_LAST = '1;
  localparam logic signed [ACC_W-1:0] PCM_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PCM_MIN = ~PCM_MAX;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] integ [N_STG];
  logic signed [ACC_W-1:0] comb  [0:N_STG];
  logic signed [ACC_W-1:0] dly   [1:N_STG];
  logic                    vld   [0:N_STG];
  logic                    emit  [0:N_STG];
  logic [LOG2_DEC-1:0]     decim_cnt;
  logic [2:0]              settle_cnt;
  logic                    dec_evt;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] pcm_sat;

  // 2'b10 is not a legal PDM code; it must never become -2.
  always_comb begin
    x = '0;
    case (pdm_i)
      2'b01:   x = {{(ACC_W-1){1'b0}}, 1'b1};
      2'b11:   x = '1;
      default: x = '0;
    endcase
  end

  assign dec_evt = pdm_val_i && (decim_cnt == CNT_LAST);

  always_comb begin
    shifted = comb[N_STG] >>> SHIFT;
    if (shifted > PCM_MAX)
      pcm_sat = PCM_MAX[OUT_W-1:0];
    else if (shifted < PCM_MIN)
      pcm_sat = PCM_MIN[OUT_W-1:0];
    else
      pcm_sat = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STG; k++) integ[k] <= '0;
      for (int k = 0; k <= N_STG; k++) begin
        comb[k] <= '0;
        vld[k]  <= 1'b0;
        emit[k] <= 1'b0;
      end
      for (int k = 1; k <= N_STG; k++) dly[k] <= '0;
      decim_cnt  <= '0;
      settle_cnt <= '0;
      pcm_o      <= '0;
      pcm_val_o  <= 1'b0;
      settled_o  <= 1'b0;
    end else if (!en_i) begin
      for (int k = 0; k < N_STG; k++) integ[k] <= '0;
      for (int k = 0; k <= N_STG; k++) begin
        comb[k] <= '0;
        vld[k]  <= 1'b0;
        emit[k] <= 1'b0;
      end
      for (int k = 1; k <= N_STG; k++) dly[k] <= '0;
      decim_cnt  <= '0;
      settle_cnt <= '0;
      pcm_o      <= '0;
      pcm_val_o  <= 1'b0;
      settled_o  <= 1'b0;
    end else begin
      if (pdm_val_i) begin
        integ[0] <= integ[0] + x;
        for (int k = 1; k < N_STG; k++) integ[k] <= integ[k] + integ[k-1];
        decim_cnt <= decim_cnt + LOG2_DEC'(1);
      end

      // Each event carries a tag saying whether its result may be emitted.
      vld[0]  <= dec_evt;
      emit[0] <= dec_evt && (settle_cnt == SETTLE_N);
      if (dec_evt) begin
        comb[0] <= integ[N_STG-1];
        if (settle_cnt != SETTLE_N) settle_cnt <= settle_cnt + 3'd1;
      end

      for (int k = 1; k <= N_STG; k++) begin
        vld[k]  <= vld[k-1];
        emit[k] <= emit[k-1];
        if (vld[k-1]) begin
          comb[k] <= comb[k-1] - dly[k];
          dly[k]  <= comb[k-1];
        end
      end

      if (vld[N_STG]) pcm_o <= pcm_sat;
      pcm_val_o <= vld[N_STG] && emit[N_STG];
      if (vld[N_STG] && emit[N_STG]) settled_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: steady-state levels, latency, settling
// suppression and abort behaviour on rst / en_i drop.
module tb_pdm_cic_decimator;

  logic              clk;
  logic              rst;
  logic              en_i;
  logic [1:0]        pdm_i;
  logic              pdm_val_i;
  logic signed [15:0] pcm_o;
  logic              pcm_val_o;
  logic              settled_o;

  int total = 0;
  int bad   = 0;

  // Strobe seen at negedge n is captured at the next posedge (edge T);
  // pcm_val_o registered at T+5 is then seen at negedge n+6.
  localparam int LAT_NE = 6;

  pdm_cic_decimator #(.LOG2_DEC(6), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .pdm_i     (pdm_i),
    .pdm_val_i (pdm_val_i),
    .pcm_o     (pcm_o),
    .pcm_val_o (pcm_val_o),
    .settled_o (settled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   ne = 0;
  int   scnt = 0;
  int   evt_q [$];
  int   vt_q  [$];
  int   vv_q  [$];
  int   wide_cnt = 0;
  int   nosettle_cnt = 0;
  logic prev_val = 1'b0;

  always @(negedge clk) begin
    ne <= ne + 1;
    if (rst || !en_i) begin
      scnt <= 0;
    end else if (pdm_val_i) begin
      scnt <= scnt + 1;
      if (((scnt + 1) % 64) == 0) evt_q.push_back(ne);
    end
    if (pcm_val_o) begin
      vt_q.push_back(ne);
      vv_q.push_back(int'(pcm_o));
      if (prev_val) wide_cnt <= wide_cnt + 1;
      if (!settled_o) nosettle_cnt <= nosettle_cnt + 1;
    end
    prev_val <= pcm_val_o;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] v);
    pdm_i     = v;
    pdm_val_i = 1'b1;
    @(posedge clk);
    #1;
    pdm_val_i = 1'b0;
    pdm_i     = 2'b00;
  endtask

  task automatic run_frames(input logic [7:0] pat, input int spacing, input int frames);
    for (int f = 0; f < frames; f++) begin
      for (int s = 0; s < 64; s++) begin
        strobe(pat[2*(s%4) +: 2]);
        if (spacing > 1) idle(spacing - 1);
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en_i      = 1'b1;
    pdm_val_i = 1'b0;
    pdm_i     = 2'b00;
    idle(3);
    rst = 1'b0;
    idle(1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] pat;
    int         spacing;
    int         frames;
    int         exp_pcm;
    int         exp_nval;
  } vec_t;

  vec_t vecs [6];

  task automatic abort_run(input bit use_rst);
    int v_before;
    string tag;
    tag = use_rst ? "rst_abort" : "en_abort";
    do_reset();
    run_frames(8'b01010101, 1, 6);
    idle(8);
    check({tag, "_settled_before"}, int'(settled_o), 1);
    v_before = vt_q.size();
    run_frames(8'b01010101, 1, 1);
    idle(1);
    #1;
    if (use_rst) rst = 1'b1;
    else         en_i = 1'b0;
    #1;
    check({tag, "_val_drop"}, int'(pcm_val_o), 0);
    idle(3);
    check({tag, "_settled"}, int'(settled_o), 0);
    check({tag, "_pcm_clr"}, int'(pcm_o), 0);
    rst  = 1'b0;
    en_i = 1'b1;
    idle(8);
    check({tag, "_discarded"}, vt_q.size() - v_before, 0);
    v_before = vt_q.size();
    run_frames(8'b01010101, 1, 4);
    idle(10);
    check({tag, "_still_suppressed"}, vt_q.size() - v_before, 0);
    run_frames(8'b01010101, 1, 1);
    idle(10);
    check({tag, "_resume_count"}, vt_q.size() - v_before, 1);
    if (vt_q.size() > v_before)
      check({tag, "_resume_pcm"}, vv_q[v_before], 32767);
    check({tag, "_resettled"}, int'(settled_o), 1);
  endtask

  initial begin
    int ev0, v0, nval, ei;

    vecs[0] = '{"pos_const",  8'b01010101, 4, 10,  32767, 6};
    vecs[1] = '{"neg_const",  8'b11111111, 1, 10, -32768, 6};
    vecs[2] = '{"p_m_m_m",    8'b11111101, 2,  8, -16384, 4};
    vecs[3] = '{"alternate",  8'b11011101, 1,  8,      0, 4};
    vecs[4] = '{"zero_illeg", 8'b00100010, 1,  8,      0, 4};
    vecs[5] = '{"zero",       8'b00000000, 3,  6,      0, 2};

    rst       = 1'b1;
    en_i      = 1'b1;
    pdm_val_i = 1'b0;
    pdm_i     = 2'b00;
    idle(2);
    check("reset_pcm",     int'(pcm_o),     0);
    check("reset_val",     int'(pcm_val_o), 0);
    check("reset_settled", int'(settled_o), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      ev0 = evt_q.size();
      v0  = vt_q.size();
      run_frames(vecs[i].pat, vecs[i].spacing, vecs[i].frames);
      idle(10);
      nval = vt_q.size() - v0;
      check({vecs[i].name, "_nval"}, nval, vecs[i].exp_nval);
      for (int j = 0; j < nval; j++) begin
        check({vecs[i].name, "_pcm"}, vv_q[v0 + j], vecs[i].exp_pcm);
        ei = ev0 + j + 4;
        if (ei < evt_q.size())
          check({vecs[i].name, "_latency"}, vt_q[v0 + j] - evt_q[ei], LAT_NE);
        else
          check({vecs[i].name, "_latency_noevt"}, -1, LAT_NE);
      end
      check({vecs[i].name, "_settled"}, int'(settled_o), 1);
    end

    abort_run(1'b1);
    abort_run(1'b0);

    check("pulse_width_1", wide_cnt, 0);
    check("settled_with_val", nosettle_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
